if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the five-stage LoongArch core, feeding the decode stage. It issues word reads on the instruction SRAM-like bus, keeps at most one request in flight, and captures returned instructions. It delivers `{pc, inst}` pairs to decode through the valid/allowin handshake. Taken branches and jumps resolved in decode redirect fetch, and the stage discards all wrong-path work.

## Interface
Parameters:
- `RESET_PC`, default `32'h1c00_0000`: address of the first fetch after reset.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `ds_allowin`  in  1  decode can accept an instruction this cycle.
- `br_bus`  in  `BR_BUS_WD` (33)  `{br_taken, br_target[31:0]}` from decode.
  - `br_taken` already includes decode-valid.
  - `br_taken` may stay high for several cycles.
- `fs_to_ds_valid`  out  1  instruction valid toward decode.
- `fs_to_ds_bus`  out  `FS_TO_DS_BUS_WD` (64)  `{fs_pc[31:0], fs_inst[31:0]}`.
- `inst_sram_req`  out  1  request valid.
- `inst_sram_wr`  out  1  constant 0.
- `inst_sram_size`  out  2  constant `2'b10` (word).
- `inst_sram_wstrb`  out  4  constant 0.
- `inst_sram_addr`  out  32  fetch address.
- `inst_sram_wdata`  out  32  constant 0.
- `inst_sram_addr_ok`  in  1  request accepted when high together with `req`.
- `inst_sram_data_ok`  in  1  read data returned for the oldest accepted request.
- `inst_sram_rdata`  in  32  instruction word, valid with `data_ok`.

## Operation
Registers:
- `state` ∈ {REQ, WAIT, HOLD}.
- `fetch_pc`: address of the next request.
- `req_pc`: address of the in-flight request.
- `cancel`.
- Output register `{fs_valid, out_pc, out_inst}`.
- One-entry buffer `{buf_pc, buf_inst}`.

Combinational outputs:
- `inst_sram_req = (state==REQ) & ~reset`.
- `inst_sram_addr = br_taken ? br_target : fetch_pc`, so a redirect is requested in the same cycle it arrives.
- `fs_to_ds_valid = fs_valid & ~br_taken`: a wrong-path instruction is never handed over.
- `fs_to_ds_bus = {out_pc, out_inst}`.

REQ state:
- On `addr_ok`: `req_pc <= inst_sram_addr`, `fetch_pc <= inst_sram_addr + 4` (mod 2^32), go to WAIT.
- `data_ok` in REQ is ignored.

WAIT state:
- On `data_ok` with (`cancel` or `br_taken`): drop the data, clear `cancel`, go to REQ.
- On `data_ok` otherwise, with the output free (`!fs_valid` or `ds_allowin`): `out <= {req_pc, rdata}`, `fs_valid <= 1`, go to REQ.
- On `data_ok` otherwise, with the output occupied: `buf <= {req_pc, rdata}`, go to HOLD.
- On `br_taken` without `data_ok`: `cancel <= 1`, stay in WAIT.

HOLD state (`fs_valid` is always 1 here):
- On `ds_allowin & ~br_taken`: `out <= buf`, go to REQ.

Output register:
- Cleared when consumed (`fs_to_ds_valid & ds_allowin`) and not refilled in the same cycle.

Redirect, applied in every cycle that `br_taken`=1:
- `fs_valid <= 0`.
- `fetch_pc <= br_target`, or `br_target + 4` if REQ and `addr_ok` in the same cycle.
- HOLD → REQ with the buffer discarded.
- WAIT → cancel as above.
- A redirect held for several cycles restarts fetch to the same target each cycle. This is correct, only slower.

Arithmetic: all PC arithmetic is 32-bit wrap-around. No alignment check.

## Timing
Reset values:
- `state`=REQ, `fetch_pc`=`RESET_PC`, `fs_valid`=0, `cancel`=0.
- `inst_sram_req`=0 while `reset` is high.
- Buffer and out_pc/out_inst contents are don't-care.

First request: in the first cycle after reset deasserts, `req`=1 with `addr`=`RESET_PC`.

Latency and throughput:
- With `addr_ok` in cycle t and `data_ok` in t+1, `fs_to_ds_valid` rises in t+2.
- Steady-state throughput is one instruction per 2 cycles plus memory wait cycles.
- One outstanding request maximum; `req` is never asserted in WAIT or HOLD.

Simultaneous events:
- `data_ok` + consume in the same cycle: the new instruction replaces the consumed one with no bubble.
- `data_ok` + `br_taken`: the data is dropped and REQ with target follows next cycle.
- Reset mid-transaction: state returns to REQ. A `data_ok` arriving later while in REQ is ignored; the bus is assumed reset together with the core.

## Structure
Constants in `mycpu.vh`:
- `FS_TO_DS_BUS_WD` = 64.
- `BR_BUS_WD` = 33.

Local to the module: the state encoding (`localparam`, 2 bits).

Single flat module with no sub-module. The datapath is two 64-bit registers plus muxes.

## Test plan
- Reset release, memory with `addr_ok`=1 and `data_ok` one cycle later, `ds_allowin`=1 → addresses 1c000000, 1c000004, 1c000008 on alternate cycles; decode receives each pc/inst pair 2 cycles after its request.
- `ds_allowin`=0 for 6 cycles → the first instruction stays held and the second goes to the buffer (HOLD, `req`=0). On release, both are delivered in order with no loss or duplication.
- `br_taken`=1 with `br_target`=1c000100 while in WAIT → the returning data is dropped, the next request is to 1c000100, and the next delivered pc is 1c000100.
- `br_taken` in REQ with `addr_ok` the same cycle → `inst_sram_addr`=target that cycle, `fetch_pc`=target+4, and `fs_to_ds_valid` is 0 in that cycle.
- `br_taken` held for 3 cycles while in HOLD → buffer and output are flushed, and only target-path instructions reach decode.
- Random `addr_ok`/`data_ok` delays of 0–5 cycles with a scoreboard → delivered pcs are strictly sequential except at redirects, and there is never more than one outstanding request.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared widths and payload types for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned FS_TO_DS_BUS_WD = 64;
    localparam int unsigned BR_BUS_WD       = 33;

    typedef enum logic [1:0] {
        FS_REQ  = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2
    } fs_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_entry_t;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

endpackage

// File: rtl/if_stage_if.sv
// SRAM-like instruction bus: the fetch stage is master, memory is slave.
interface if_stage_if;

    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: one outstanding word read, one-entry skid buffer,
// redirect from decode cancels any wrong-path fetch or held instruction.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ds_allowin,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       fs_to_ds_valid,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    if_stage_if.master                 inst_sram
);

    fs_state_e   state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic        cancel_q, cancel_d;
    logic        fs_valid_q, fs_valid_d;
    fs_entry_t   out_q, out_d;
    fs_entry_t   buf_q, buf_d;

    br_bus_t     br;
    logic        fire;
    logic        out_free;

    assign br = br_bus_t'(br_bus);

    // Redirect target goes out on the bus in the same cycle it arrives.
    assign inst_sram.req   = (state_q == FS_REQ) & ~reset;
    assign inst_sram.addr  = br.taken ? br.target : fetch_pc_q;
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = 2'b10;
    assign inst_sram.wstrb = 4'b0000;
    assign inst_sram.wdata = 32'h0000_0000;

    assign fs_to_ds_valid = fs_valid_q & ~br.taken;
    assign fs_to_ds_bus   = FS_TO_DS_BUS_WD'(out_q);

    assign fire     = inst_sram.req & inst_sram.addr_ok;
    assign out_free = ~fs_valid_q | ds_allowin;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        cancel_d   = cancel_q;
        fs_valid_d = fs_valid_q;
        out_d      = out_q;
        buf_d      = buf_q;

        if (fs_to_ds_valid && ds_allowin) begin
            fs_valid_d = 1'b0;
        end

        unique case (state_q)
            FS_REQ: begin
                if (fire) begin
                    req_pc_d   = inst_sram.addr;
                    fetch_pc_d = 32'(inst_sram.addr + 32'd4);
                    state_d    = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (inst_sram.data_ok) begin
                    if (cancel_q || br.taken) begin
                        cancel_d = 1'b0;
                        state_d  = FS_REQ;
                    end else if (out_free) begin
                        out_d      = '{pc: req_pc_q, inst: inst_sram.rdata};
                        fs_valid_d = 1'b1;
                        state_d    = FS_REQ;
                    end else begin
                        buf_d   = '{pc: req_pc_q, inst: inst_sram.rdata};
                        state_d = FS_HOLD;
                    end
                end else if (br.taken) begin
                    cancel_d = 1'b1;
                end
            end
            FS_HOLD: begin
                if (ds_allowin && !br.taken) begin
                    out_d      = buf_q;
                    fs_valid_d = 1'b1;
                    state_d    = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase

        // Redirect flushes the output; an accepted redirect already set target+4.
        if (br.taken) begin
            fs_valid_d = 1'b0;
            if (!((state_q == FS_REQ) && fire)) begin
                fetch_pc_d = br.target;
            end
            if (state_q == FS_HOLD) begin
                state_d = FS_REQ;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FS_REQ;
            fetch_pc_q <= RESET_PC;
            fs_valid_q <= 1'b0;
            cancel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fs_valid_q <= fs_valid_d;
            cancel_q   <= cancel_d;
        end
    end

    // Payload registers carry no reset; fs_valid_q qualifies them.
    always_ff @(posedge clk) begin
        req_pc_q <= req_pc_d;
        out_q    <= out_d;
        buf_q    <= buf_d;
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: the bench plays memory and decode cycle by cycle.
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h1c00_0000;
    localparam logic [31:0] I0 = 32'h0280_0401;
    localparam logic [31:0] I1 = 32'h0280_0802;
    localparam logic [31:0] I2 = 32'h0280_0c03;
    localparam logic [31:0] I3 = 32'hdead_beef;
    localparam logic [31:0] I4 = 32'h0280_1004;
    localparam logic [31:0] I5 = 32'h0280_1405;
    localparam logic [31:0] I6 = 32'h0280_1806;
    localparam logic [31:0] I7 = 32'h0280_1c07;
    localparam logic [31:0] I8 = 32'h0280_2008;
    localparam logic [31:0] I9 = 32'h0280_2409;
    localparam logic [31:0] T1 = 32'h1c00_0100;
    localparam logic [31:0] T2 = 32'h1c00_0200;
    localparam logic [31:0] T3 = 32'h1c00_0300;

    logic                       clk;
    logic                       reset;
    logic                       ds_allowin;
    logic [BR_BUS_WD-1:0]       br_bus;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;

    int n_assert = 0;
    int n_fail   = 0;

    if_stage_if sram ();

    if_stage #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .ds_allowin     (ds_allowin),
        .br_bus         (br_bus),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .inst_sram      (sram.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the edge, then settle before checks.
    task automatic step(input logic rst, input logic ao, input logic dok, input logic allow,
                        input logic brt, input logic [31:0] tgt, input logic [31:0] rd);
        @(posedge clk);
        #1;
        reset        = rst;
        sram.addr_ok = ao;
        sram.data_ok = dok;
        sram.rdata   = rd;
        ds_allowin   = allow;
        br_bus       = {brt, tgt};
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        ds_allowin   = 1'b0;
        br_bus       = '0;
        sram.addr_ok = 1'b0;
        sram.data_ok = 1'b0;
        sram.rdata   = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("rst_req", 64'(sram.req), 64'd0);
        chk("rst_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("const_size", 64'(sram.size), 64'd2);
        chk("const_wr", 64'({sram.wr, sram.wstrb, sram.wdata}), 64'd0);

        // Back-to-back fetch with one-cycle memory
        step(0, 1, 0, 1, 0, 0, 0);                      // C1
        chk("c1_req", 64'(sram.req), 64'd1);
        chk("c1_addr", 64'(sram.addr), 64'(RST_PC));
        chk("c1_valid", 64'(fs_to_ds_valid), 64'd0);
        step(0, 0, 1, 1, 0, 0, I0);                     // C2
        chk("c2_req", 64'(sram.req), 64'd0);
        step(0, 1, 0, 1, 0, 0, 0);                      // C3
        chk("c3_addr", 64'(sram.addr), 64'h1c00_0004);
        chk("c3_valid", 64'(fs_to_ds_valid), 64'd1);
        chk("c3_bus", fs_to_ds_bus, {RST_PC, I0});
        step(0, 0, 1, 1, 0, 0, I1);                     // C4
        chk("c4_valid", 64'(fs_to_ds_valid), 64'd0);

        // Decode stalls for six cycles
        step(0, 1, 0, 0, 0, 0, 0);                      // C5
        chk("c5_addr", 64'(sram.addr), 64'h1c00_0008);
        chk("c5_bus", fs_to_ds_bus, {32'h1c00_0004, I1});
        step(0, 0, 1, 0, 0, 0, I2);                     // C6
        step(0, 0, 0, 0, 0, 0, 0);                      // C7
        chk("c7_hold_req", 64'(sram.req), 64'd0);
        step(0, 0, 0, 0, 0, 0, 0);                      // C8
        step(0, 0, 0, 0, 0, 0, 0);                      // C9
        step(0, 0, 0, 0, 0, 0, 0);                      // C10
        chk("c10_hold_req", 64'(sram.req), 64'd0);
        chk("c10_valid", 64'(fs_to_ds_valid), 64'd1);
        chk("c10_bus", fs_to_ds_bus, {32'h1c00_0004, I1});
        step(0, 0, 0, 1, 0, 0, 0);                      // C11 release
        chk("c11_bus", fs_to_ds_bus, {32'h1c00_0004, I1});
        step(0, 0, 0, 1, 0, 0, 0);                      // C12, memory slow
        chk("c12_req", 64'(sram.req), 64'd1);
        chk("c12_addr", 64'(sram.addr), 64'h1c00_000c);
        chk("c12_valid", 64'(fs_to_ds_valid), 64'd1);
        chk("c12_bus", fs_to_ds_bus, {32'h1c00_0008, I2});
        step(0, 1, 0, 1, 0, 0, 0);                      // C13
        chk("c13_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("c13_addr", 64'(sram.addr), 64'h1c00_000c);

        // Redirect while waiting: in-flight data must be dropped
        step(0, 0, 0, 1, 1, T1, 0);                     // C14
        chk("c14_req", 64'(sram.req), 64'd0);
        step(0, 0, 1, 1, 0, 0, I3);                     // C15
        step(0, 1, 0, 1, 0, 0, 0);                      // C16
        chk("c16_req", 64'(sram.req), 64'd1);
        chk("c16_addr", 64'(sram.addr), 64'(T1));
        chk("c16_valid", 64'(fs_to_ds_valid), 64'd0);
        step(0, 0, 1, 1, 0, 0, I4);                     // C17

        // Redirect in REQ accepted the same cycle
        step(0, 1, 0, 1, 1, T2, 0);                     // C18
        chk("c18_addr", 64'(sram.addr), 64'(T2));
        chk("c18_valid", 64'(fs_to_ds_valid), 64'd0);
        step(0, 0, 1, 0, 0, 0, I5);                     // C19
        step(0, 1, 0, 0, 0, 0, 0);                      // C20
        chk("c20_addr", 64'(sram.addr), 64'h1c00_0204);
        chk("c20_bus", fs_to_ds_bus, {T2, I5});
        step(0, 0, 1, 0, 0, 0, I6);                     // C21

        // Redirect held three cycles while in HOLD
        step(0, 0, 0, 1, 1, T3, 0);                     // C22
        chk("c22_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("c22_req", 64'(sram.req), 64'd0);
        step(0, 0, 0, 1, 1, T3, 0);                     // C23
        chk("c23_req", 64'(sram.req), 64'd1);
        chk("c23_addr", 64'(sram.addr), 64'(T3));
        chk("c23_valid", 64'(fs_to_ds_valid), 64'd0);
        step(0, 1, 0, 1, 1, T3, 0);                     // C24
        step(0, 0, 1, 1, 0, 0, I7);                     // C25
        chk("c25_valid", 64'(fs_to_ds_valid), 64'd0);
        step(0, 0, 0, 1, 0, 0, 0);                      // C26
        chk("c26_bus", fs_to_ds_bus, {T3, I7});
        chk("c26_valid", 64'(fs_to_ds_valid), 64'd1);
        chk("c26_addr", 64'(sram.addr), 64'h1c00_0304);

        // Stray data_ok in REQ is ignored
        step(0, 0, 1, 1, 0, 0, I3);                     // C27
        chk("c27_valid", 64'(fs_to_ds_valid), 64'd0);
        step(0, 1, 0, 1, 0, 0, 0);                      // C28
        chk("c28_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("c28_addr", 64'(sram.addr), 64'h1c00_0304);
        step(0, 0, 1, 1, 0, 0, I8);                     // C29

        // data_ok coinciding with consume: no bubble
        step(0, 1, 0, 0, 0, 0, 0);                      // C30
        chk("c30_bus", fs_to_ds_bus, {32'h1c00_0304, I8});
        chk("c30_addr", 64'(sram.addr), 64'h1c00_0308);
        step(0, 0, 1, 1, 0, 0, I9);                     // C31
        chk("c31_valid", 64'(fs_to_ds_valid), 64'd1);
        chk("c31_bus", fs_to_ds_bus, {32'h1c00_0304, I8});
        step(0, 1, 0, 0, 0, 0, 0);                      // C32
        chk("c32_valid", 64'(fs_to_ds_valid), 64'd1);
        chk("c32_bus", fs_to_ds_bus, {32'h1c00_0308, I9});
        chk("c32_addr", 64'(sram.addr), 64'h1c00_030c);

        // Reset mid-transaction, late data_ok afterwards
        step(1, 0, 0, 0, 0, 0, 0);                      // C33
        chk("c33_req", 64'(sram.req), 64'd0);
        step(0, 0, 1, 1, 0, 0, I3);                     // C34
        chk("c34_req", 64'(sram.req), 64'd1);
        chk("c34_addr", 64'(sram.addr), 64'(RST_PC));
        chk("c34_valid", 64'(fs_to_ds_valid), 64'd0);
        step(0, 0, 0, 1, 0, 0, 0);                      // C35
        chk("c35_valid", 64'(fs_to_ds_valid), 64'd0);
        chk("c35_req", 64'(sram.req), 64'd1);
        chk("c35_addr", 64'(sram.addr), 64'(RST_PC));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
